// File: rtl/btn_debouncer_if.sv
// Signal bundle between a raw button source and the debouncer.
// The master drives the raw level; the slave (debouncer) returns the conditioned outputs.
interface btn_debouncer_if;
    logic btn_in;
    logic db_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (
        output btn_in,
        input  db_out,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  btn_in,
        output db_out,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser followed by a stability-qualifying FSM that produces a clean
// level plus one-cycle rise/fall strobes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_LOW     | accepted level 0, waiting for sync1 to go high
// WAIT_HIGH | sync1 high, counting stable cycles before accepting 1
// S_HIGH    | accepted level 1, waiting for sync1 to go low
// WAIT_LOW  | sync1 low, counting stable cycles before accepting 0
module btn_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    btn_debouncer_if.slave  dbif
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW,
        WAIT_HIGH,
        S_HIGH,
        WAIT_LOW
    } state_t;

    logic                 sync0;
    logic                 sync1;
    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic                 db_q;
    logic                 db_nx;
    logic                 rise_q;
    logic                 rise_nx;
    logic                 fall_q;
    logic                 fall_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            state  <= S_LOW;
            cnt    <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync0  <= dbif.btn_in;
            sync1  <= sync0;
            state  <= state_nx;
            cnt    <= cnt_nx;
            db_q   <= db_nx;
            rise_q <= rise_nx;
            fall_q <= fall_nx;
        end
    end

    // A revert on the terminal-count edge wins over acceptance.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        db_nx    = db_q;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            S_LOW: begin
                if (sync1) begin
                    state_nx = WAIT_HIGH;
                    cnt_nx   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync1) begin
                    state_nx = S_LOW;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_HIGH;
                    db_nx    = 1'b1;
                    rise_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_WIDTH'(1);
                end
            end
            S_HIGH: begin
                if (!sync1) begin
                    state_nx = WAIT_LOW;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync1) begin
                    state_nx = S_HIGH;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_LOW;
                    db_nx    = 1'b0;
                    fall_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nx = S_LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    assign dbif.db_out     = db_q;
    assign dbif.rise_pulse = rise_q;
    assign dbif.fall_pulse = fall_q;
    assign dbif.busy       = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: doc/btn_debouncer.md
# btn_debouncer

Input-conditioning stage that sits directly upstream of the single-bit D flip-flop register (`clk`/`d`/`q`). It takes a raw, asynchronous, bouncing push-button or switch signal and synchronises it to `clk`. It then filters it with a stability counter, and presents a clean level (`db_out`) suitable for driving the flip-flop's `d` input. It also provides one-cycle rise/fall strobes for downstream counters and FSMs.

## Interface
- `STABLE_CYCLES`, default 50000: consecutive synchronised cycles the new level must hold before it is accepted (1 ms at 50 MHz). Legal range 2 to 2^`CNT_WIDTH`-1.
- `CNT_WIDTH`, default 16: width of the stability counter.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `btn_in`  in  1  raw asynchronous button/switch level; may bounce or glitch.
- `db_out`  out  1  debounced level, registered.
- `rise_pulse`  out  1  one-cycle strobe on an accepted 0->1 transition of `db_out`.
- `fall_pulse`  out  1  one-cycle strobe on an accepted 1->0 transition of `db_out`.
- `busy`  out  1  high while a candidate transition is being qualified (FSM in a WAIT state).

## Operation
- Synchroniser: two flops, `sync0` <= `btn_in` and `sync1` <= `sync0`. `sync1` is the only copy of the input used by the FSM. No logic sits between the two flops.
- FSM states: S_LOW, WAIT_HIGH, S_HIGH, WAIT_LOW.
- In S_LOW, `db_out`=0:
  - `sync1`=1 -> WAIT_HIGH, cnt <= 0.
  - Otherwise stay in S_LOW.
- In WAIT_HIGH:
  - `sync1`=0 -> S_LOW, cnt <= 0, no pulse.
  - `sync1`=1 and cnt == `STABLE_CYCLES`-1 -> S_HIGH, `db_out` <= 1, `rise_pulse` <= 1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- S_HIGH and WAIT_LOW mirror S_LOW and WAIT_HIGH with levels inverted; they drive `fall_pulse`.
- The counter compares against `STABLE_CYCLES`-1 using `CNT_WIDTH`-bit unsigned arithmetic. It never exceeds `STABLE_CYCLES`-1 and never wraps.
- `busy` = (state == WAIT_HIGH or WAIT_LOW), decoded from registered state.
- `rise_pulse` and `fall_pulse` are registered, are high for exactly one cycle, and are never high together.
- Reset (`rst_n`=0 at a rising edge), regardless of state:
  - `sync0`=0, `sync1`=0, state=S_LOW, cnt=0.
  - `db_out`=0, `rise_pulse`=0, `fall_pulse`=0, `busy`=0.
- Reset mid-qualification aborts the qualification with no pulse.
- If `btn_in`=1 when reset is released, the normal qualification runs and produces a `rise_pulse`.

## Timing
- Latency: `btn_in` changes and is first sampled at edge E. It then holds stable. `sync1` reflects the new level after E+1. FSM enters WAIT after E+2. `db_out` and the pulse update after edge E+`STABLE_CYCLES`+2. Latency is `STABLE_CYCLES`+3 edges, counting E.
- Pulse timing: the pulse is asserted in the same cycle that `db_out` first shows the new value. It deasserts on the following edge.
- Glitch rejection: any excursion of `sync1` lasting `STABLE_CYCLES` cycles or fewer returns the FSM to the stable state with `db_out` unchanged.
- Simultaneous events:
  - A revert on the same edge where cnt == `STABLE_CYCLES`-1 is a revert. No transition occurs.
  - Reset overrides every other event.
- Throughput: at most one accepted transition per `STABLE_CYCLES`+1 cycles.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `CNT_WIDTH`=3.
- Reset: hold `rst_n`=0 for 3 cycles with `btn_in`=1 -> `db_out`, `rise_pulse`, `fall_pulse` and `busy` all read 0. After release, `db_out`=1 appears 7 edges later.
- Clean press: `btn_in` 0->1 sampled at edge E, then held -> `busy`=1 after E+2. `db_out`=1 and `rise_pulse`=1 after E+6. `rise_pulse`=0 after E+7. `fall_pulse` stays 0 throughout.
- Bounce: press, then toggle `btn_in` 1,0,1,0 on successive cycles, then hold 1 -> `db_out` stays 0 during the bounce. Exactly one `rise_pulse`, 7 edges after the final stable 1 is sampled.
- Glitch: with `db_out`=1, drive `btn_in`=0 for 3 cycles, then back to 1 -> `db_out` stays 1, no `fall_pulse`, `busy` returns to 0.
- Release: with `db_out`=1, drive `btn_in`=0 and hold -> exactly one `fall_pulse`, and `db_out`=0 after 7 edges.
- Reset mid-WAIT: assert `rst_n`=0 for one cycle while `busy`=1 and cnt=2 -> next cycle shows state S_LOW, `db_out`=0, no pulse. A held `btn_in`=1 then requalifies from the start.
